// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller for a four-function calculator. It turns single-cycle
// key strobes into operand digit writes, operator latching, compute start and
// clear commands. Every output is registered and appears one cycle after the
// key that caused it.
module calc_entry_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       calc_done,
  output logic [3:0] digit_out,
  output logic       new_number,
  output logic       op_number,
  output logic [1:0] digit_number,
  output logic       op_received,
  output logic [1:0] operation,
  output logic       clear_ops,
  output logic       calc_start,
  output logic       busy,
  output logic       result_valid,
  output logic       key_err
);

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_CALC   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  // A digit typed while a result is shown is stored here. It is written into
  // operand 1 on the cycle after clear_ops, so the datapath has already
  // zeroed both operands before the write arrives.
  logic       pend, pend_nxt;
  logic [3:0] pend_digit, pend_digit_nxt;

  logic [3:0] digit_out_nxt;
  logic       new_number_nxt, op_number_nxt, op_received_nxt;
  logic [1:0] digit_number_nxt, operation_nxt;
  logic       clear_ops_nxt, calc_start_nxt, busy_nxt, result_valid_nxt, key_err_nxt;

  logic is_digit, is_op, is_eq, is_clr;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = (key_code == 4'd14);
  assign is_clr   = (key_code == 4'd15);

  // Next-state and next-output decode for one key / calc_done event.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves a combinational output unassigned, which would infer a latch.
    state_nxt        = state;
    cnt_nxt          = cnt;
    pend_nxt         = 1'b0;
    pend_digit_nxt   = pend_digit;
    digit_out_nxt    = digit_out;
    digit_number_nxt = digit_number;
    op_number_nxt    = op_number;
    operation_nxt    = operation;
    new_number_nxt   = 1'b0;
    op_received_nxt  = 1'b0;
    clear_ops_nxt    = 1'b0;
    calc_start_nxt   = 1'b0;
    key_err_nxt      = 1'b0;

    if (pend) begin
      // Second half of starting a new entry from a shown result; any key
      // arriving now is dropped, including clear.
      new_number_nxt   = 1'b1;
      digit_out_nxt    = pend_digit;
      digit_number_nxt = 2'd0;
      op_number_nxt    = 1'b0;
      cnt_nxt          = 3'd1;
      state_nxt        = S_OP1;
      key_err_nxt      = key_valid;
    end else if (key_valid && is_clr) begin
      // Clear wins over everything, including a simultaneous calc_done.
      clear_ops_nxt = 1'b1;
      state_nxt     = S_OP1;
      cnt_nxt       = 3'd0;
      op_number_nxt = 1'b0;
      operation_nxt = 2'b00;
    end else begin
      unique case (state)
        S_OP1, S_OP2: begin
          if (key_valid) begin
            if (is_digit) begin
              if (cnt < MAX_DIGITS) begin
                new_number_nxt   = 1'b1;
                digit_out_nxt    = key_code;
                digit_number_nxt = cnt[1:0];
                cnt_nxt          = cnt + 3'd1;
              end else begin
                key_err_nxt = 1'b1;
              end
            end else if (is_op) begin
              if (state == S_OP1 && cnt != 3'd0) begin
                op_received_nxt = 1'b1;
                // Operator codes 10..13 map to 00..11.
                operation_nxt   = key_code[1:0] + 2'd2;
                op_number_nxt   = 1'b1;
                cnt_nxt         = 3'd0;
                state_nxt       = S_OP2;
              end else begin
                key_err_nxt = 1'b1;
              end
            end else if (is_eq) begin
              if (state == S_OP2 && cnt != 3'd0) begin
                calc_start_nxt = 1'b1;
                state_nxt      = S_CALC;
              end else begin
                key_err_nxt = 1'b1;
              end
            end
          end
        end
        S_CALC: begin
          // Keys other than clear are silently ignored while computing.
          if (calc_done) state_nxt = S_RESULT;
        end
        S_RESULT: begin
          if (key_valid) begin
            if (is_digit) begin
              clear_ops_nxt  = 1'b1;
              pend_nxt       = 1'b1;
              pend_digit_nxt = key_code;
              cnt_nxt        = 3'd0;
              state_nxt      = S_OP1;
            end else begin
              key_err_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = S_OP1;
      endcase
    end

    busy_nxt         = (state_nxt == S_CALC);
    result_valid_nxt = (state_nxt == S_RESULT);
  end

  // State, counter and registered outputs; reset abandons any sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_OP1;
      cnt          <= 3'd0;
      pend         <= 1'b0;
      pend_digit   <= 4'd0;
      digit_out    <= 4'd0;
      new_number   <= 1'b0;
      op_number    <= 1'b0;
      digit_number <= 2'd0;
      op_received  <= 1'b0;
      operation    <= 2'b00;
      clear_ops    <= 1'b0;
      calc_start   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      key_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pend         <= pend_nxt;
      pend_digit   <= pend_digit_nxt;
      digit_out    <= digit_out_nxt;
      new_number   <= new_number_nxt;
      op_number    <= op_number_nxt;
      digit_number <= digit_number_nxt;
      op_received  <= op_received_nxt;
      operation    <= operation_nxt;
      clear_ops    <= clear_ops_nxt;
      calc_start   <= calc_start_nxt;
      busy         <= busy_nxt;
      result_valid <= result_valid_nxt;
      key_err      <= key_err_nxt;
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios followed by
// random key / calc_done / reset traffic, all compared each cycle against a
// behavioural model of the calculator entry rules.
module tb_calc_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       calc_done;
  logic [3:0] digit_out;
  logic       new_number;
  logic       op_number;
  logic [1:0] digit_number;
  logic       op_received;
  logic [1:0] operation;
  logic       clear_ops;
  logic       calc_start;
  logic       busy;
  logic       result_valid;
  logic       key_err;

  always #5 clk = ~clk;

  calc_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .calc_done    (calc_done),
    .digit_out    (digit_out),
    .new_number   (new_number),
    .op_number    (op_number),
    .digit_number (digit_number),
    .op_received  (op_received),
    .operation    (operation),
    .clear_ops    (clear_ops),
    .calc_start   (calc_start),
    .busy         (busy),
    .result_valid (result_valid),
    .key_err      (key_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: phase 1 = entering operand 1, 2 = operand 2, 3 = computing,
  // 4 = result shown. The digits of the operand being typed are kept in a queue.
  int m_phase;
  int m_digits[$];
  bit m_pend;
  int m_pend_val;
  int e_digit_out, e_new_number, e_op_number, e_digit_number, e_op_received;
  int e_operation, e_clear_ops, e_calc_start, e_busy, e_result_valid, e_key_err;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("digit_out",    8'(digit_out),    8'(e_digit_out));
    check("new_number",   8'(new_number),   8'(e_new_number));
    check("op_number",    8'(op_number),    8'(e_op_number));
    check("digit_number", 8'(digit_number), 8'(e_digit_number));
    check("op_received",  8'(op_received),  8'(e_op_received));
    check("operation",    8'(operation),    8'(e_operation));
    check("clear_ops",    8'(clear_ops),    8'(e_clear_ops));
    check("calc_start",   8'(calc_start),   8'(e_calc_start));
    check("busy",         8'(busy),         8'(e_busy));
    check("result_valid", 8'(result_valid), 8'(e_result_valid));
    check("key_err",      8'(key_err),      8'(e_key_err));
  endtask

  task automatic model_reset();
    m_phase = 1;
    m_digits.delete();
    m_pend = 0;
    m_pend_val = 0;
    e_digit_out = 0; e_new_number = 0; e_op_number = 0; e_digit_number = 0;
    e_op_received = 0; e_operation = 0; e_clear_ops = 0; e_calc_start = 0;
    e_busy = 0; e_result_valid = 0; e_key_err = 0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit cd);
    e_new_number = 0; e_op_received = 0; e_clear_ops = 0;
    e_calc_start = 0; e_key_err = 0;
    if (m_pend) begin
      m_pend = 0;
      m_digits.delete();
      m_digits.push_back(m_pend_val);
      e_new_number = 1; e_digit_out = m_pend_val; e_digit_number = 0; e_op_number = 0;
      if (kv) e_key_err = 1;
    end else if (kv && kc == 15) begin
      e_clear_ops = 1;
      m_phase = 1;
      m_digits.delete();
      e_op_number = 0;
      e_operation = 0;
    end else if (m_phase == 3) begin
      if (cd) m_phase = 4;
    end else if (kv) begin
      if (kc < 10) begin
        if (m_phase == 4) begin
          e_clear_ops = 1;
          m_pend = 1;
          m_pend_val = kc;
          m_phase = 1;
          m_digits.delete();
        end else if (m_digits.size() == 4) begin
          e_key_err = 1;
        end else begin
          e_new_number = 1; e_digit_out = kc; e_digit_number = m_digits.size();
          m_digits.push_back(kc);
        end
      end else if (kc < 14) begin
        if (m_phase == 1 && m_digits.size() > 0) begin
          e_op_received = 1; e_operation = kc - 10; e_op_number = 1;
          m_phase = 2;
          m_digits.delete();
        end else begin
          e_key_err = 1;
        end
      end else begin
        if (m_phase == 2 && m_digits.size() > 0) begin
          e_calc_start = 1;
          m_phase = 3;
        end else begin
          e_key_err = 1;
        end
      end
    end
    e_busy = (m_phase == 3);
    e_result_valid = (m_phase == 4);
  endtask

  // One clock: apply inputs, advance the model, check outputs just after the edge.
  task automatic cycle(input bit kv, input int kc, input bit cd);
    key_valid = kv;
    key_code  = kc[3:0];
    calc_done = cd;
    model_step(kv, kc, cd);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic press(input int kc);
    cycle(1'b1, kc, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, int'($urandom_range(0, 15)), 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    key_valid = 1'b0;
    calc_done = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    calc_done = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Digits 1,2,3 into operand 1.
    press(1); press(2); idle(1); press(3); idle(1);

    // Fresh entry: 4 5 + 6 = then compute and show the result.
    press(15);
    press(4); press(5); press(10); press(6); press(14);
    idle(3);
    cycle(1'b0, 0, 1'b1);
    idle(2);

    // Fifth digit rejected.
    press(15);
    press(1); press(2); press(3); press(4); press(5); idle(1);

    // Operator with empty operand, then '=' with empty operand 2.
    async_reset();
    press(12); press(7); press(13); press(14); idle(1);

    // Reach result, then digit restarts entry; also a key during the restart.
    press(8); press(14); cycle(1'b0, 0, 1'b1); idle(1);
    press(9); idle(2);
    press(15); press(2); press(11); press(3); press(14); cycle(1'b0, 0, 1'b1);
    press(12); press(14); press(5); press(6); idle(1);

    // Clear wins over simultaneous calc_done; then reset inside S_CALC.
    press(15); press(1); press(10); press(1); press(14);
    cycle(1'b1, 15, 1'b1); idle(1);
    press(1); press(12); press(2); press(14); idle(1);
    async_reset(); idle(2);

    // Reset while the restart digit is pending.
    press(3); press(13); press(4); press(14); cycle(1'b0, 0, 1'b1);
    press(7);
    async_reset(); idle(2);

    // calc_done outside S_CALC is ignored.
    cycle(1'b0, 0, 1'b1); press(5); cycle(1'b0, 0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r, u, kc;
      bit kv, cd;
      r = int'($urandom_range(0, 199));
      if (r < 3) begin
        async_reset();
      end else begin
        kv = ($urandom_range(0, 99) < 55);
        u  = int'($urandom_range(0, 99));
        if (u < 55)      kc = int'($urandom_range(0, 9));
        else if (u < 78) kc = int'($urandom_range(10, 13));
        else if (u < 93) kc = 14;
        else             kc = 15;
        cd = ($urandom_range(0, 99) < 20);
        cycle(kv, kc, cd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
